lfsr_rng_arbiter: RTL and testbench
===================================

# lfsr_rng_arbiter

Shared pseudo-random word server. It owns one 16-bit Fibonacci LFSR (taps 15, 13, 12, 10) and hands fresh random words to up to NREQ requesters under round-robin arbitration. Each requester receives a word that is STEPS shifts past the previous delivery. Software can reseed the generator at any time. The block sits between the onboarding LFSR datapath and the client blocks that previously each instantiated their own generator.

## Interface
- NREQ, default 4: number of requesters, 2..8.
- STEPS, default 4: LFSR shifts between consecutive deliveries, 1..16.
- RESET_SEED, default 16'hACE1: LFSR value after reset, also substituted for an all-zero seed. Must be non-zero.

- clk, input, 1: clock; all state updates on the rising edge.
- nReset, input, 1: asynchronous, active-low reset.
- seed_load, input, 1: one-cycle strobe that loads `seed` into the LFSR.
- seed, input, 16: new LFSR value, sampled when seed_load=1.
- req, input, NREQ: per-requester level request; held until the matching gnt bit is seen.
- gnt, output, NREQ: one-hot, one-cycle grant/delivery strobe.
- rnd_valid, output, 1: high in the delivery cycle; always equals |gnt.
- rnd_data, output, 16: random word, valid when rnd_valid=1.
- rnd_id, output, $clog2(NREQ): index of the served requester, valid when rnd_valid=1.
- busy, output, 1: high in the STEP and DELIVER states.

## Operation
- LFSR step rule: next = {s[14:0], s[15]^s[13]^s[12]^s[10]}.
- The LFSR advances only in STEP; it holds in every other state.
- State machine: IDLE, STEP, DELIVER.
- IDLE, no request: stay in IDLE.
- IDLE, any req bit high: round-robin pick.
  - Search starts at index last_gnt+1 and wraps modulo NREQ.
  - Latch the winner index, load step counter = STEPS-1, go to STEP.
- STEP: shift the LFSR once per cycle.
  - When counter = 0, go to DELIVER; otherwise decrement.
- DELIVER, for exactly one cycle:
  - gnt[idx]=1, rnd_valid=1, rnd_data = current LFSR, rnd_id = idx.
  - last_gnt <= idx, then return to IDLE.
- A latched grant is committed: if the requester drops req during STEP, delivery still occurs and the requester ignores it.
- seed_load has priority over everything in every state:
  - LFSR <= (seed==0) ? RESET_SEED : seed.
  - State goes to IDLE and any in-flight STEP/DELIVER is aborted with no gnt.
  - last_gnt is unchanged.
  - A req present during a seed_load cycle is not arbitrated in that cycle.
- Reset (asynchronous, nReset=0):
  - LFSR = RESET_SEED, state = IDLE, last_gnt = NREQ-1, so requester 0 wins first.
  - gnt = 0, rnd_valid = 0, rnd_data = 0, rnd_id = 0, busy = 0.
- Reset asserted mid-sequence aborts it immediately; no partial delivery.
- The all-zero LFSR state is unreachable: reset and seed_load both exclude it, and the step rule preserves non-zero.

## Timing
- Request sampled in IDLE at edge E0.
- STEP occupies cycles E0+1 .. E0+STEPS.
- gnt/rnd_valid are high in cycle E0+STEPS+1.
- Request-to-grant latency = STEPS+1 cycles; one delivery per STEPS+2 cycles at full load.
- Back-to-back service: DELIVER -> IDLE -> arbitration in the following cycle; no delivery in the IDLE cycle.
- All outputs decode from registered state; there are no combinational paths from req or seed to any output.
- seed_load takes effect at the same edge it is sampled.

## Test plan
- Reset, then req=4'b0001 with STEPS=4: gnt=4'b0001 5 cycles later, rnd_data=16'hCE1E (sequence ACE1→59C3→B387→670F→CE1E), rnd_id=0.
- seed_load with seed=16'h0001, then req=4'b0100: rnd_data=16'h0010, rnd_id=2.
- seed_load with seed=16'h0000: next delivery equals the post-reset value 16'hCE1E.
- req=4'b1111 held for 4 deliveries after reset: rnd_id sequence 0,1,2,3; then req=4'b1010: sequence 1,3,1.
- seed_load asserted in the second STEP cycle: no gnt for the aborted request; busy=0 next cycle; the still-held req is re-served with data derived from the new seed.
- nReset pulsed low during DELIVER: gnt/rnd_valid drop asynchronously, LFSR=ACE1, and the first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/lfsr_rng_arbiter.sv
// Shared 16-bit Fibonacci LFSR word server with round-robin delivery to NREQ clients.
module lfsr_rng_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned STEPS      = 4,
  parameter logic [15:0] RESET_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     nReset,
  input  logic                     seed_load,
  input  logic [15:0]              seed,
  input  logic [NREQ-1:0]          req,
  output logic [NREQ-1:0]          gnt,
  output logic                     rnd_valid,
  output logic [15:0]              rnd_data,
  output logic [$clog2(NREQ)-1:0]  rnd_id,
  output logic                     busy
);

  localparam int unsigned IDW  = $clog2(NREQ);
  localparam int unsigned CNTW = 4;
  localparam int unsigned LFW  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP    = 2'd1,
    DELIVER = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [LFW-1:0]    lfsr_q, lfsr_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]    idx_q, idx_d;
  logic [IDW-1:0]    last_gnt_q, last_gnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              rnd_valid_q, rnd_valid_d;
  logic [LFW-1:0]    rnd_data_q, rnd_data_d;
  logic [IDW-1:0]    rnd_id_q, rnd_id_d;
  logic              busy_q, busy_d;

  logic              pick_found;
  logic [IDW-1:0]    pick_idx;

  // One Fibonacci shift with taps 15, 13, 12, 10.
  function automatic logic [LFW-1:0] lfsr_step(input logic [LFW-1:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Round-robin search starting just after the last served requester.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      if (!pick_found && req[IDW'((32'(last_gnt_q) + i) % NREQ)]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'((32'(last_gnt_q) + i) % NREQ);
      end
    end
  end

  // Next-state, datapath and registered-output computation; seed_load overrides all.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    last_gnt_d  = last_gnt_q;
    gnt_d       = '0;
    rnd_valid_d = 1'b0;
    rnd_data_d  = '0;
    rnd_id_d    = '0;
    busy_d      = 1'b0;

    if (seed_load) begin
      lfsr_d  = (seed == '0) ? RESET_SEED : seed;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            idx_d   = pick_idx;
            cnt_d   = CNTW'(STEPS - 1);
            state_d = STEP;
          end
        end
        STEP: begin
          lfsr_d = lfsr_step(lfsr_q);
          if (cnt_q == '0) begin
            state_d = DELIVER;
          end else begin
            cnt_d = cnt_q - CNTW'(1);
          end
        end
        DELIVER: begin
          last_gnt_d = idx_q;
          state_d    = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    if (state_d == DELIVER) begin
      gnt_d       = NREQ'(1) << idx_d;
      rnd_valid_d = 1'b1;
      rnd_data_d  = lfsr_d;
      rnd_id_d    = idx_d;
    end
    busy_d = (state_d == STEP) || (state_d == DELIVER);
  end

  // State and output registers; reset makes requester 0 the first winner.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      lfsr_q      <= RESET_SEED;
      cnt_q       <= '0;
      idx_q       <= '0;
      last_gnt_q  <= IDW'(NREQ - 1);
      gnt_q       <= '0;
      rnd_valid_q <= 1'b0;
      rnd_data_q  <= '0;
      rnd_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      last_gnt_q  <= last_gnt_d;
      gnt_q       <= gnt_d;
      rnd_valid_q <= rnd_valid_d;
      rnd_data_q  <= rnd_data_d;
      rnd_id_q    <= rnd_id_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd_valid = rnd_valid_q;
  assign rnd_data  = rnd_data_q;
  assign rnd_id    = rnd_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Directed and randomized checks of lfsr_rng_arbiter against a transaction-level model.
module tb_lfsr_rng_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned STEPS  = 4;
  localparam logic [15:0] RSEED  = 16'hACE1;
  localparam int          BUDGET = 200;

  logic              clk;
  logic              nReset;
  logic              seed_load;
  logic [15:0]       seed;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   gnt;
  logic              rnd_valid;
  logic [15:0]       rnd_data;
  logic [1:0]        rnd_id;
  logic              busy;

  int total = 0;
  int bad   = 0;

  // Model state: current generator word and last served requester.
  logic [15:0] m_lfsr;
  int          m_last;
  bit          rand_seed;

  lfsr_rng_arbiter #(
    .NREQ(NREQ), .STEPS(STEPS), .RESET_SEED(RSEED)
  ) dut (
    .clk(clk), .nReset(nReset), .seed_load(seed_load), .seed(seed),
    .req(req), .gnt(gnt), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
    .rnd_id(rnd_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance a word n shifts using feedback = xor of bits 15,13,12,10.
  function automatic logic [15:0] advance(input logic [15:0] s, input int n);
    int v = int'(s);
    for (int k = 0; k < n; k++) begin
      int fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
      v = ((v << 1) | fb) & 16'hFFFF;
    end
    return 16'(v);
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] m, input int last);
    for (int k = 1; k <= int'(NREQ); k++) begin
      int c = (last + k) % int'(NREQ);
      if (m[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_seed(input logic [15:0] s);
    m_lfsr = (s == 16'h0) ? RSEED : s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nReset    = 1'b0;
    req       = '0;
    seed_load = 1'b0;
    m_lfsr    = RSEED;
    m_last    = NREQ - 1;
    @(negedge clk);
    chk("rst_gnt",   32'(gnt), 32'h0);
    chk("rst_valid", 32'(rnd_valid), 32'h0);
    chk("rst_data",  32'(rnd_data), 32'h0);
    chk("rst_id",    32'(rnd_id), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    nReset = 1'b1;
  endtask

  // One-cycle seed strobe issued while the block is idle.
  task automatic pulse_seed(input logic [15:0] s);
    @(negedge clk);
    seed_load = 1'b1;
    seed      = s;
    model_seed(s);
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  // Wait for the next delivery and compare it with the model's prediction.
  task automatic expect_delivery(input string tag, input int exp_lat,
                                 output int got_id, output logic [15:0] got_data);
    int          cyc  = 0;
    bit          seen = 0;
    int          eid;
    logic [15:0] edata;
    got_id   = -1;
    got_data = '0;
    while (!seen && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (rnd_valid) begin
        seen = 1;
      end else begin
        chk({tag, "_idle_gnt"}, 32'(gnt), 32'h0);
        if (seed_load) begin
          seed_load = 1'b0;
        end else if (rand_seed && $urandom_range(0, 15) == 0) begin
          seed_load = 1'b1;
          seed      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
          model_seed(seed);
        end
      end
    end
    total++;
    assert (seen) else begin
      bad++;
      $error("FAIL %s_timeout observed=no_grant expected=grant_within_%0d", tag, BUDGET);
    end
    if (seen) begin
      eid   = rr_pick(req, m_last);
      edata = advance(m_lfsr, STEPS);
      chk({tag, "_gnt"},  32'(gnt), 32'(1) << eid);
      chk({tag, "_id"},   32'(rnd_id), 32'(eid));
      chk({tag, "_data"}, 32'(rnd_data), 32'(edata));
      chk({tag, "_vld"},  32'(rnd_valid), 32'(|gnt));
      chk({tag, "_busy"}, 32'(busy), 32'h1);
      if (exp_lat >= 0) chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
      m_lfsr   = edata;
      m_last   = eid;
      got_id   = int'(rnd_id);
      got_data = rnd_data;
    end
  endtask

  int          gid;
  logic [15:0] gdata;

  initial begin
    nReset    = 1'b0;
    seed_load = 1'b0;
    seed      = '0;
    req       = '0;
    rand_seed = 0;
    m_lfsr    = RSEED;
    m_last    = NREQ - 1;

    // Reset state, then a single request from requester 0.
    do_reset();
    @(negedge clk);
    req = 4'b0001;
    expect_delivery("first", STEPS + 1, gid, gdata);
    chk("first_const_data", 32'(gdata), 32'hCE1E);
    chk("first_const_id", 32'(gid), 32'd0);
    req = '0;

    // Seed 0001 shifts a single bit left.
    pulse_seed(16'h0001);
    req = 4'b0100;
    expect_delivery("seed1", STEPS + 1, gid, gdata);
    chk("seed1_const_data", 32'(gdata), 32'h0010);
    chk("seed1_const_id", 32'(gid), 32'd2);
    req = '0;

    // Zero seed substitutes the reset seed.
    pulse_seed(16'h0000);
    req = 4'b0001;
    expect_delivery("seed0", STEPS + 1, gid, gdata);
    chk("seed0_const_data", 32'(gdata), 32'hCE1E);
    req = '0;

    // Full load after reset: 0,1,2,3 then 1,3,1 with back-to-back spacing.
    do_reset();
    @(negedge clk);
    req = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      expect_delivery("all", (n == 0) ? int'(STEPS + 1) : int'(STEPS + 2), gid, gdata);
      chk("all_const_id", 32'(gid), 32'(n));
    end
    req = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      expect_delivery("odd", STEPS + 2, gid, gdata);
      chk("odd_const_id", 32'(gid), (n == 1) ? 32'd3 : 32'd1);
    end
    req = '0;

    // Seed strobe in the second STEP cycle aborts the in-flight request.
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    seed_load = 1'b1;
    seed      = 16'h1234;
    model_seed(16'h1234);
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_gnt", 32'(gnt), 32'h0);
    chk("abort_vld", 32'(rnd_valid), 32'h0);
    seed_load = 1'b0;
    expect_delivery("abort_reserve", STEPS + 1, gid, gdata);
    chk("abort_const_id", 32'(gid), 32'd2);
    req = '0;

    // Asynchronous reset in the DELIVER cycle.
    @(negedge clk);
    req = 4'b1000;
    expect_delivery("pre_rst", STEPS + 1, gid, gdata);
    #1;
    nReset = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt), 32'h0);
    chk("async_vld", 32'(rnd_valid), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    m_lfsr = RSEED;
    m_last = NREQ - 1;
    req    = 4'b1111;
    @(negedge clk);
    nReset = 1'b1;
    expect_delivery("post_rst", STEPS + 1, gid, gdata);
    chk("post_rst_const_id", 32'(gid), 32'd0);
    chk("post_rst_const_data", 32'(gdata), 32'hCE1E);
    req = req & ~(NREQ'(1) << gid);

    // Random arrivals and random seed strobes against the model.
    rand_seed = 1;
    for (int n = 0; n < 150; n++) begin
      if (req == '0) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      end
      expect_delivery("rand", -1, gid, gdata);
      if (gid >= 0) req = req & ~(NREQ'(1) << gid);
      req = req | (NREQ'($urandom) & NREQ'($urandom));
    end
    rand_seed = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
